// File: rtl/sha_message_scheduler_seq_pkg.sv
// Shared SHA-256 message-schedule definitions: word/history types, FSM states,
// block/schedule sizes and the small sigma functions.
package sha_message_scheduler_seq_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned SCHED_WORDS = 64;

    typedef logic [WORD_W-1:0]                   word_t;
    // Element [0] is the newest word, element [15] the oldest.
    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] hist_t;

    typedef enum logic {
        ST_LOAD,
        ST_EMIT
    } state_e;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_message_scheduler_seq_if.sv
// Word-stream bundle: message words in, schedule words W_t out.
interface sha_message_scheduler_seq_if;
    import sha_message_scheduler_seq_pkg::*;

    logic        in_valid;
    logic        in_ready;
    word_t       in_word;
    logic        out_valid;
    logic        out_ready;
    word_t       out_word;
    logic [5:0]  out_index;
    logic        out_last;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_index, out_last
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_index, out_last
    );

endinterface

// File: rtl/sha_message_scheduler_seq_expander_round.sv
// One schedule-expansion step: W_t from the 16-word history (h[0] = W_{t-1}).
module sha_message_expander_round
    import sha_message_scheduler_seq_pkg::*;
(
    input  hist_t hist_i,
    output word_t w_o
);

    always_comb begin
        w_o = sigma1(hist_i[1]) + hist_i[6] + sigma0(hist_i[14]) + hist_i[15];
    end

endmodule

// File: rtl/sha_message_scheduler_seq.sv
// Sequential SHA-256 message scheduler: loads 16 words, then streams W0..W63
// from a 16-entry shift history with valid/ready on both sides.
module sha_message_scheduler_seq
    import sha_message_scheduler_seq_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    sha_message_scheduler_seq_if.slave  bus
);

    state_e      state_q, state_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [5:0]  t_q, t_d;
    hist_t       hist_q, hist_d;
    word_t       w_exp;
    word_t       emit_word;

    sha_message_expander_round u_round (
        .hist_i (hist_q),
        .w_o    (w_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= '0;
            t_q        <= '0;
            hist_q     <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            hist_q     <= hist_d;
        end
    end

    // For t<16 the oldest entry is recirculated, so after 16 emits the
    // history is back in load order and expansion continues seamlessly.
    always_comb begin
        emit_word = (t_q < 6'(BLOCK_WORDS)) ? hist_q[BLOCK_WORDS-1] : w_exp;
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        hist_d     = hist_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.in_valid) begin
                    hist_d     = {hist_q[BLOCK_WORDS-2:0], bus.in_word};
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'(BLOCK_WORDS - 1)) begin
                        state_d = ST_EMIT;
                        t_d     = '0;
                    end
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    hist_d = {hist_q[BLOCK_WORDS-2:0], emit_word};
                    if (t_q == 6'(SCHED_WORDS - 1)) begin
                        state_d    = ST_LOAD;
                        t_d        = '0;
                        load_cnt_d = '0;
                    end else begin
                        t_d = t_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_LOAD) && !rst;
    assign bus.out_valid = (state_q == ST_EMIT);
    assign bus.out_word  = (state_q == ST_EMIT) ? emit_word : '0;
    assign bus.out_index = t_q;
    assign bus.out_last  = (state_q == ST_EMIT) && (t_q == 6'(SCHED_WORDS - 1));

endmodule

// File: tb/tb_sha_message_scheduler_seq.sv
// Directed bench for sha_message_scheduler_seq: abc block, stalls, input gaps,
// back-to-back blocks and mid-block resets against an independent schedule model.
module tb_sha_message_scheduler_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sha_message_scheduler_seq_if bus();

    sha_message_scheduler_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycles;

    logic [31:0] blk   [16];
    logic [31:0] ref_w [64];
    logic [31:0] got   [64];

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_ref();
        for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            ref_w[t] = s1(ref_w[t-2]) + ref_w[t-7] + s0(ref_w[t-15]) + ref_w[t-16];
    endtask

    task automatic load_abc();
        blk[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) blk[i] = 32'h0;
        blk[15] = 32'h00000018;
    endtask

    task automatic load_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_word"},  bus.out_word,       32'd0);
        check({tag, "_out_index"}, 32'(bus.out_index), 32'd0);
        check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    endtask

    task automatic do_reset(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, "_rel_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Drives one block in and drains its schedule; abort_in/abort_out >= 0
    // pulse rst after that many words have been accepted/emitted.
    task automatic run_block(input string tag, input int gap_pct, input int stall_pct,
                             input bit hold_valid, input int abort_in, input int abort_out);
        int          in_cnt;
        int          out_cnt;
        bit          prev_stall;
        logic [31:0] prev_word;
        bit          done;
        in_cnt     = 0;
        out_cnt    = 0;
        prev_stall = 1'b0;
        prev_word  = '0;
        done       = 1'b0;
        cycles     = 0;
        build_ref();
        while (!done) begin
            @(negedge clk);
            cycles++;
            if (cycles > 2000) begin
                check({tag, "_timeout_words"}, 32'(out_cnt), 32'd64);
                done = 1'b1;
            end else if ((abort_in >= 0 && in_cnt == abort_in) ||
                         (abort_out >= 0 && out_cnt == abort_out && in_cnt == 16)) begin
                do_reset({tag, "_rst"});
                done = 1'b1;
            end else begin
                if (in_cnt < 16) begin
                    bus.in_valid = ($urandom_range(99) >= gap_pct);
                    bus.in_word  = bus.in_valid ? blk[in_cnt] : $urandom;
                end else begin
                    bus.in_valid = hold_valid;
                    bus.in_word  = $urandom;
                end
                bus.out_ready = ($urandom_range(99) >= stall_pct);
                #1;
                if (in_cnt < 16) begin
                    check({tag, "_load_in_ready"},  32'(bus.in_ready),  32'd1);
                    check({tag, "_load_out_valid"}, 32'(bus.out_valid), 32'd0);
                    if (bus.in_valid) in_cnt++;
                end else begin
                    check({tag, "_emit_in_ready"},  32'(bus.in_ready),  32'd0);
                    check({tag, "_emit_out_valid"}, 32'(bus.out_valid), 32'd1);
                    check($sformatf("%s_w%0d", tag, out_cnt), bus.out_word, ref_w[out_cnt]);
                    check($sformatf("%s_idx%0d", tag, out_cnt), 32'(bus.out_index), 32'(out_cnt));
                    check($sformatf("%s_last%0d", tag, out_cnt), 32'(bus.out_last),
                          32'(out_cnt == 63));
                    if (prev_stall)
                        check($sformatf("%s_hold%0d", tag, out_cnt), bus.out_word, prev_word);
                    prev_stall = !bus.out_ready;
                    prev_word  = bus.out_word;
                    if (bus.out_ready) begin
                        got[out_cnt] = bus.out_word;
                        out_cnt++;
                        if (out_cnt == 64) done = 1'b1;
                    end
                end
            end
        end
        if (out_cnt == 64) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
            #1;
            check({tag, "_after_in_ready"},  32'(bus.in_ready),  32'd1);
            check({tag, "_after_out_valid"}, 32'(bus.out_valid), 32'd0);
            check({tag, "_after_out_last"},  32'(bus.out_last),  32'd0);
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_word  = 32'hdeadbeef;
        #1;
        check_reset_outputs("por_hold");
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("por_rel_in_ready", 32'(bus.in_ready), 32'd1);

        load_abc();
        run_block("abc", 0, 0, 1'b0, -1, -1);
        check("abc_cycles", 32'(cycles), 32'd80);
        check("abc_W16", got[16], 32'h61626380);
        check("abc_W17", got[17], 32'h000F0000);

        run_block("abc_stall", 0, 50, 1'b0, -1, -1);

        load_random();
        run_block("gap", 40, 0, 1'b1, -1, -1);

        load_random();
        run_block("b2b_a", 0, 20, 1'b1, -1, -1);
        load_random();
        run_block("b2b_b", 0, 0, 1'b1, -1, -1);

        load_abc();
        run_block("abort_emit", 0, 0, 1'b0, -1, 30);
        load_random();
        run_block("abort_load", 0, 0, 1'b0, 7, -1);
        load_abc();
        run_block("post_rst", 0, 30, 1'b0, -1, -1);
        check("post_rst_W16", got[16], 32'h61626380);
        check("post_rst_W0",  got[0],  32'h61626380);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
